// File: rtl/uart_puf_ctrl.sv
// Host command sequencer between a byte-wide UART and a PUF evaluation core.
// Parses PING/EVAL commands, launches one evaluation and streams status + response bytes back.
module uart_puf_ctrl #(
  parameter int unsigned          DATA_BITS      = 8,
  parameter int unsigned          CHAL_BYTES     = 4,
  parameter int unsigned          RESP_BYTES     = 4,
  parameter logic [DATA_BITS-1:0] CMD_PING       = 8'h50,
  parameter logic [DATA_BITS-1:0] CMD_EVAL       = 8'hC1,
  parameter logic [DATA_BITS-1:0] ACK            = 8'hAA,
  parameter logic [DATA_BITS-1:0] NACK           = 8'h55,
  parameter int unsigned          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [DATA_BITS-1:0]             rx_data,
  input  logic                             rx_valid,
  output logic                             rx_enable,
  output logic [DATA_BITS-1:0]             tx_data,
  output logic                             tx_enable,
  input  logic                             tx_busy,
  output logic [CHAL_BYTES*DATA_BITS-1:0]  puf_challenge,
  output logic                             puf_start,
  input  logic                             puf_done,
  input  logic [RESP_BYTES*DATA_BITS-1:0]  puf_response,
  output logic                             busy,
  output logic                             error
);

  localparam int unsigned CHW = CHAL_BYTES * DATA_BITS;
  localparam int unsigned RW  = RESP_BYTES * DATA_BITS;
  localparam int unsigned CW  = $clog2(CHAL_BYTES + 1);
  localparam int unsigned IW  = $clog2(RESP_BYTES + 2);
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] CHAL_LAST = CW'(CHAL_BYTES - 1);
  localparam logic [IW-1:0] RESP_LAST = IW'(RESP_BYTES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_CHAL,
    S_START,
    S_WAIT_PUF,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  state_e               state_q,    state_d;
  logic [CHW-1:0]       chal_q,     chal_d;
  logic [CW-1:0]        chal_cnt_q, chal_cnt_d;
  logic [TW-1:0]        tmo_q,      tmo_d;
  logic [RW-1:0]        resp_q,     resp_d;
  logic [DATA_BITS-1:0] status_q,   status_d;
  logic [IW-1:0]        idx_q,      idx_d;
  logic [IW-1:0]        last_q,     last_d;
  logic                 error_q,    error_d;
  logic [DATA_BITS-1:0] tx_byte;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      chal_q     <= '0;
      chal_cnt_q <= '0;
      tmo_q      <= '0;
      resp_q     <= '0;
      status_q   <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      chal_cnt_q <= chal_cnt_d;
      tmo_q      <= tmo_d;
      resp_q     <= resp_d;
      status_q   <= status_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    chal_cnt_d = chal_cnt_q;
    resp_d     = resp_q;
    status_d   = status_q;
    idx_d      = idx_q;
    last_d     = last_q;
    error_d    = 1'b0;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_PING) begin
            status_d = ACK;
            idx_d    = '0;
            last_d   = '0;
            state_d  = S_ISSUE;
          end else if (rx_data == CMD_EVAL) begin
            chal_cnt_d = '0;
            state_d    = S_RECV_CHAL;
          end else begin
            status_d = NACK;
            idx_d    = '0;
            last_d   = '0;
            error_d  = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_RECV_CHAL: begin
        // An arriving byte takes priority over a timeout in the same cycle.
        if (rx_valid) begin
          chal_d = (chal_q << DATA_BITS) | CHW'(rx_data);
          if (chal_cnt_q == CHAL_LAST) state_d = S_START;
          else                         chal_cnt_d = chal_cnt_q + 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          status_d = NACK;
          idx_d    = '0;
          last_d   = '0;
          error_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_START: state_d = S_WAIT_PUF;
      S_WAIT_PUF: begin
        if (puf_done) begin
          resp_d   = puf_response;
          status_d = ACK;
          idx_d    = '0;
          last_d   = RESP_LAST;
          state_d  = S_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          status_d = NACK;
          idx_d    = '0;
          last_d   = '0;
          error_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE:   if (!tx_busy) state_d = S_WAIT_HI;
      S_WAIT_HI: if (tx_busy)  state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == last_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout restarts on every state change and on each challenge byte; otherwise saturates.
    if (state_d != state_q || (state_q == S_RECV_CHAL && rx_valid)) tmo_d = '0;
    else if (tmo_q != TMO_LAST)                                    tmo_d = tmo_q + 1'b1;
  end

  always_comb begin
    tx_byte = status_q;
    for (int unsigned i = 0; i < RESP_BYTES; i++) begin
      if (idx_q == IW'(i + 1)) tx_byte = resp_q[(RESP_BYTES-1-i)*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    rx_enable     = (state_q == S_IDLE) || (state_q == S_RECV_CHAL);
    tx_enable     = (state_q == S_ISSUE) && !tx_busy;
    tx_data       = tx_byte;
    puf_start     = (state_q == S_START);
    puf_challenge = chal_q;
    busy          = (state_q != S_IDLE);
    error         = error_q;
  end

endmodule

// File: tb/tb_uart_puf_ctrl.sv
// Directed/randomized bench for uart_puf_ctrl with a behavioural UART TX model and reply reference model.
module tb_uart_puf_ctrl;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_enable;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_busy = 1'b0;
  logic [31:0] puf_challenge;
  logic        puf_start;
  logic        puf_done = 1'b0;
  logic [31:0] puf_response = '0;
  logic        busy;
  logic        error;

  uart_puf_ctrl #(
    .DATA_BITS      (8),
    .CHAL_BYTES     (4),
    .RESP_BYTES     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_enable     (rx_enable),
    .tx_data       (tx_data),
    .tx_enable     (tx_enable),
    .tx_busy       (tx_busy),
    .puf_challenge (puf_challenge),
    .puf_start     (puf_start),
    .puf_done      (puf_done),
    .puf_response  (puf_response),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_log[$];
  logic [7:0]  exp_q[$];
  int          err_pulses = 0;
  int          start_pulses = 0;
  logic [31:0] chal_at_start = '0;
  logic [31:0] shadow_chal = '0;

  // UART transmitter model: busy rises the cycle after a send request, stays high 2..6 cycles.
  int         busy_left = 0;
  bit         pending = 0;
  logic [7:0] cur_byte = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      tx_busy   = 1'b0;
      pending   = 0;
      busy_left = 0;
    end else if (tx_enable) begin
      checks++;
      assert (tx_busy === 1'b0) else begin
        errors++;
        $error("FAIL tx_enable_while_busy: observed tx_busy=%0b expected 0", tx_busy);
      end
      tx_log.push_back(tx_data);
      cur_byte = tx_data;
      pending  = 1;
    end else if (pending) begin
      pending   = 0;
      tx_busy   = 1'b1;
      busy_left = $urandom_range(2, 6);
    end else if (tx_busy) begin
      checks++;
      assert (tx_data === cur_byte) else begin
        errors++;
        $error("FAIL tx_data_stable: observed %0h expected %0h", tx_data, cur_byte);
      end
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (error) err_pulses++;
    if (puf_start) begin
      start_pulses++;
      chal_at_start = puf_challenge;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_enable"}, 64'(rx_enable), 64'd1);
    check({tag, "_tx_enable"}, 64'(tx_enable), 64'd0);
    check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    check({tag, "_puf_start"}, 64'(puf_start), 64'd0);
    check({tag, "_puf_challenge"}, 64'(puf_challenge), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference reply: status byte, then nresp response bytes, most significant first.
  task automatic expect_reply(input logic [7:0] status, input logic [31:0] resp, input int nresp);
    exp_q.delete();
    exp_q.push_back(status);
    for (int i = 0; i < nresp; i++) exp_q.push_back(resp[31-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_reached"}, 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_tx(input string tag);
    check({tag, "_tx_count"}, 64'(tx_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("%s_tx_byte%0d", tag, i), 64'(tx_log[i]), 64'(exp_q[i]));
    tx_log.delete();
  endtask

  task automatic send_challenge(input logic [31:0] chal);
    send_byte(8'hC1);
    for (int i = 0; i < 4; i++) begin
      send_byte(chal[31-8*i -: 8]);
      shadow_chal = (shadow_chal << 8) | 32'(chal[31-8*i -: 8]);
    end
  endtask

  task automatic do_ping(input string tag);
    err_pulses = 0;
    send_byte(8'h50);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_rx_enable_low"}, 64'(rx_enable), 64'd0);
    wait_idle(tag);
    expect_reply(8'hAA, 32'h0, 0);
    cmp_tx(tag);
    check({tag, "_no_error"}, 64'(err_pulses), 64'd0);
    check({tag, "_rx_enable_back"}, 64'(rx_enable), 64'd1);
  endtask

  task automatic do_eval(input logic [31:0] chal, input logic [31:0] resp, input string tag);
    start_pulses = 0;
    err_pulses   = 0;
    send_challenge(chal);
    check({tag, "_start_latency"}, 64'(puf_start), 64'd1);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    puf_response = resp;
    puf_done     = 1'b1;
    @(negedge clk);
    puf_done     = 1'b0;
    check({tag, "_tx_latency"}, 64'(tx_enable), 64'd1);
    wait_idle(tag);
    check({tag, "_challenge"}, 64'(chal_at_start), 64'(chal));
    check({tag, "_challenge_hold"}, 64'(puf_challenge), 64'(shadow_chal));
    check({tag, "_start_pulses"}, 64'(start_pulses), 64'd1);
    check({tag, "_no_error"}, 64'(err_pulses), 64'd0);
    expect_reply(8'hAA, resp, 4);
    cmp_tx(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  cmd;
    logic [31:0] chal;
    int          n;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    do_ping("ping");

    for (int k = 0; k < 4; k++) begin
      if (k == 0) cmd = 8'h12;
      else begin
        do cmd = 8'($urandom_range(0, 255));
        while (cmd == 8'h50 || cmd == 8'hC1);
      end
      err_pulses = 0;
      send_byte(cmd);
      wait_idle($sformatf("unknown%0d", k));
      expect_reply(8'h55, 32'h0, 0);
      cmp_tx($sformatf("unknown%0d", k));
      check($sformatf("unknown%0d_error_pulses", k), 64'(err_pulses), 64'd1);
      check($sformatf("unknown%0d_rx_enable", k), 64'(rx_enable), 64'd1);
    end

    do_eval(32'hDEADBEEF, 32'h01234567, "eval_fixed");
    for (int k = 0; k < 3; k++) do_eval($urandom, $urandom, $sformatf("eval_rand%0d", k));

    // Challenge byte timeout: partial challenge stays shifted in.
    start_pulses = 0;
    err_pulses   = 0;
    send_byte(8'hC1);
    send_byte(8'h11);
    shadow_chal = (shadow_chal << 8) | 32'h11;
    repeat (TMO - 10) @(negedge clk);
    check("rx_tmo_still_waiting", 64'(busy), 64'd1);
    check("rx_tmo_nothing_sent", 64'(tx_log.size()), 64'd0);
    wait_idle("rx_tmo");
    expect_reply(8'h55, 32'h0, 0);
    cmp_tx("rx_tmo");
    check("rx_tmo_no_start", 64'(start_pulses), 64'd0);
    check("rx_tmo_error_pulses", 64'(err_pulses), 64'd1);
    check("rx_tmo_partial_chal", 64'(puf_challenge), 64'(shadow_chal));
    do_ping("ping_after_rx_tmo");

    // PUF timeout with a dropped byte while waiting; timeout edge checked exactly.
    start_pulses = 0;
    err_pulses   = 0;
    chal = $urandom;
    send_challenge(chal);
    repeat (3) @(negedge clk);
    check("puf_tmo_rx_enable_low", 64'(rx_enable), 64'd0);
    send_byte(8'h50);
    check("puf_tmo_drop_chal", 64'(puf_challenge), 64'(chal));
    repeat (TMO - 5) @(negedge clk);
    check("puf_tmo_not_yet", 64'(tx_enable), 64'd0);
    @(negedge clk);
    check("puf_tmo_fires", 64'(tx_enable), 64'd1);
    wait_idle("puf_tmo");
    expect_reply(8'h55, 32'h0, 0);
    cmp_tx("puf_tmo");
    check("puf_tmo_error_pulses", 64'(err_pulses), 64'd1);
    check("puf_tmo_start_pulses", 64'(start_pulses), 64'd1);

    // puf_done arriving in the very cycle the timeout would fire wins.
    err_pulses = 0;
    send_challenge($urandom);
    repeat (TMO) @(negedge clk);
    check("tie_still_waiting", 64'(busy & ~tx_enable), 64'd1);
    puf_response = 32'hCAFEF00D;
    puf_done     = 1'b1;
    @(negedge clk);
    puf_done     = 1'b0;
    wait_idle("tie");
    expect_reply(8'hAA, 32'hCAFEF00D, 4);
    cmp_tx("tie");
    check("tie_no_error", 64'(err_pulses), 64'd0);

    // Reset while the third response byte is on the wire.
    send_challenge(32'h0BADF00D);
    @(negedge clk);
    puf_response = 32'h89ABCDEF;
    puf_done     = 1'b1;
    @(negedge clk);
    puf_done     = 1'b0;
    n = 0;
    while (tx_log.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_byte3", 64'(tx_log.size()), 64'd4);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tx_log.delete();
    shadow_chal = '0;
    @(negedge clk);
    do_ping("ping_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_puf_ctrl.md
Name: uart_puf_ctrl

Overview:
Command sequencer between the board UART (byte-wide RX/TX handshake) and the PUF evaluation core. It parses host command bytes, assembles a multi-byte challenge and launches one PUF evaluation. It then serialises a status byte plus the response bytes back through the UART transmitter, one byte at a time. It is the only master of the UART TX path and of puf_start.

Parameters:
DATA_BITS, 8, UART payload width.
CHAL_BYTES, 4, challenge length in bytes (>=1).
RESP_BYTES, 4, response length in bytes (>=1).
CMD_PING, 8'h50, command answered by ACK only.
CMD_EVAL, 8'hC1, command followed by CHAL_BYTES challenge bytes.
ACK, 8'hAA, success status byte.
NACK, 8'h55, error status byte.
TIMEOUT_CYCLES, 5_000_000, inter-byte RX timeout and PUF-completion timeout (100 ms at 50 MHz).

Ports:
clk  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
rx_data  in  DATA_BITS  received byte, valid with rx_valid
rx_valid  in  1  one-cycle strobe per received byte
rx_enable  out  1  enables UART reception
tx_data  out  DATA_BITS  byte to transmit, stable from tx_enable until tx_busy falls
tx_enable  out  1  one-cycle send request
tx_busy  in  1  UART transmitter busy
puf_challenge  out  CHAL_BYTES*DATA_BITS  assembled challenge, first received byte in MSBs
puf_start  out  1  one-cycle evaluation strobe
puf_done  in  1  one-cycle completion strobe
puf_response  in  RESP_BYTES*DATA_BITS  response, sampled in the cycle puf_done=1
busy  out  1  high in every state except IDLE
error  out  1  one-cycle pulse when a NACK is queued

Behaviour:
- Reset (async assert, sync release): state=IDLE; rx_enable=1; tx_enable=0; tx_data=0; puf_start=0; puf_challenge=0; busy=0; error=0; all counters and the response register are 0.
- rx_enable=1 only in IDLE and RECV_CHAL. Bytes arriving in any other state are dropped.
- IDLE: on rx_valid:
  - rx_data==CMD_PING -> queue ACK only, go to SEND.
  - rx_data==CMD_EVAL -> clear the byte counter and the timeout counter, go to RECV_CHAL.
  - any other value -> queue NACK, pulse error, go to SEND.
- RECV_CHAL: each rx_valid shifts rx_data into puf_challenge from the LSB side and clears the timeout counter.
  - After byte CHAL_BYTES -> START.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no byte -> queue NACK, pulse error, go to SEND; puf_challenge keeps the partial value.
- START: puf_start=1 for exactly one cycle, clear the timeout counter, go to WAIT_PUF.
- WAIT_PUF:
  - puf_done -> latch puf_response, queue ACK followed by RESP_BYTES bytes, MSB byte first, go to SEND.
  - Timeout -> queue NACK, pulse error, go to SEND.
  - puf_done in the same cycle as the timeout: puf_done wins.
- SEND is three sub-states per byte:
  - ISSUE: wait for tx_busy=0, then drive tx_data and assert tx_enable for one cycle.
  - WAIT_HI: wait for tx_busy=1.
  - WAIT_LO: wait for tx_busy=0. If bytes remain -> ISSUE for the next byte, else -> IDLE.
  - tx_enable is never asserted while tx_busy=1.
- Byte count for EVAL success = 1+RESP_BYTES. The byte index counter is ceil(log2(RESP_BYTES+2)) bits and must not wrap.
- Timeout counter is ceil(log2(TIMEOUT_CYCLES)) bits and saturates. It is cleared on every state entry.
- Minimum latency: from the last challenge rx_valid to puf_start = 1 cycle; from puf_done to the first tx_enable = 1 cycle when tx_busy=0.
- resetn asserted mid-operation aborts immediately to the reset values; any partially sent UART frame is the transmitter's responsibility.

Test Plan:
- PING: rx byte 0x50 -> tx_enable once with tx_data=0xAA, busy high until tx_busy falls, then IDLE, error never pulses.
- Unknown command: rx 0x12 -> error pulses once, single tx byte 0x55, back to IDLE with rx_enable=1.
- EVAL: rx 0xC1,0xDE,0xAD,0xBE,0xEF -> puf_challenge=0xDEADBEEF and a single puf_start pulse. Then puf_done with puf_response=0x01234567 -> tx sequence 0xAA,0x01,0x23,0x45,0x67, and each tx_enable occurs only after tx_busy falls.
- RX timeout: rx 0xC1,0x11 then silence for TIMEOUT_CYCLES (set to 100 in the bench) -> NACK 0x55 sent, no puf_start; a following PING answers 0xAA.
- PUF timeout and drop: during WAIT_PUF, inject rx_valid 0x50 -> ignored, rx_enable=0. With no puf_done for TIMEOUT_CYCLES -> NACK, error pulse.
- Reset mid-send: deassert resetn during the third EVAL response byte -> all outputs return to reset values at once. After release, PING returns 0xAA.
